// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared opcode type and constants for the shift unit
package shift_pkg;

    localparam int SHIFT_DATA_W  = 32;
    localparam int SHIFT_SHAMT_W = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

endpackage : shift_pkg

// File: rtl/shift_if.sv
// rtl/shift_if.sv - operand/result bundle between a requester and the shift unit
interface shift_if
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);

    shift_op_e           shift_ctrl;
    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   shift_src;
    logic [DATA_W-1:0]   shift_out;

    modport master (
        output shift_ctrl,
        output shamt,
        output shift_src,
        input  shift_out
    );

    modport slave (
        input  shift_ctrl,
        input  shamt,
        input  shift_src,
        output shift_out
    );

endinterface : shift_if

// File: rtl/shift_barrel_shifter.sv
// rtl/shift_barrel_shifter.sv - combinational 5-stage logarithmic shifter/rotator
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  shift_op_e           op_i,
    input  logic [SHAMT_W-1:0]  shamt_i,
    input  logic [DATA_W-1:0]   src_i,
    output logic [DATA_W-1:0]   result_o
);

    // stage_w[0] is the operand; stage_w[s+1] has optionally moved by 2**s places
    logic [DATA_W-1:0] stage_w [SHAMT_W+1];

    // The sign bit survives every SRA stage, so the original MSB is the fill source
    logic sign_w;
    assign sign_w     = src_i[DATA_W-1];
    assign stage_w[0] = src_i;

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int K = 1 << s;
        logic [DATA_W-1:0] moved_w;

        // Move this stage's input by K places, the vacated bits filled per opcode
        always_comb begin
            moved_w = stage_w[s];
            case (op_i)
                SHIFT_SLL: moved_w = {stage_w[s][DATA_W-1-K:0], {K{1'b0}}};
                SHIFT_SRL: moved_w = {{K{1'b0}}, stage_w[s][DATA_W-1:K]};
                SHIFT_SRA: moved_w = {{K{sign_w}}, stage_w[s][DATA_W-1:K]};
                SHIFT_ROR: moved_w = {stage_w[s][K-1:0], stage_w[s][DATA_W-1:K]};
                default:   moved_w = stage_w[s];
            endcase
        end

        assign stage_w[s+1] = shamt_i[s] ? moved_w : stage_w[s];
    end

    assign result_o = stage_w[SHAMT_W];

endmodule : barrel_shifter

// File: rtl/shift.sv
// rtl/shift.sv - registered shift unit: barrel shifter plus output register
module shift
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic   clk,
    input  logic   reset,
    shift_if.slave bus
);

    logic [DATA_W-1:0] shift_out_d;
    logic [DATA_W-1:0] shift_out_q;

    barrel_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_barrel_shifter (
        .op_i     (bus.shift_ctrl),
        .shamt_i  (bus.shamt),
        .src_i    (bus.shift_src),
        .result_o (shift_out_d)
    );

    // Capture a fresh result every edge; reset overrides and drops any pending result
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_out_q <= '0;
        end else begin
            shift_out_q <= shift_out_d;
        end
    end

    assign bus.shift_out = shift_out_q;

endmodule : shift

// File: tb/tb_shift.sv
// tb/tb_shift.sv - self-checking bench for the shift unit
module tb_shift;
    import shift_pkg::*;

    logic clk;
    logic reset;

    shift_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

    shift #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        shift_op_e   op;
        logic [4:0]  sh;
        logic [31:0] src;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   errors;
    int   checks;

    function automatic logic [31:0] ref_shift(shift_op_e op, logic [4:0] sh, logic [31:0] src);
        logic [63:0] dbl;
        int          n;
        n   = int'(sh);
        dbl = {src, src};
        case (op)
            SHIFT_SLL: return src << n;
            SHIFT_SRL: return src >> n;
            SHIFT_SRA: return 32'($signed(src) >>> n);
            default:   return 32'(dbl >> n);
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample one unit after the following rising edge
    task automatic cycle(logic rst, shift_op_e op, logic [4:0] sh, logic [31:0] src);
        @(negedge clk);
        reset         = rst;
        bus.shift_ctrl = op;
        bus.shamt     = sh;
        bus.shift_src = src;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_v;
    logic [31:0] held_v;
    shift_op_e   r_op;
    logic [4:0]  r_sh;
    logic [31:0] r_src;
    logic        r_rst;

    initial begin
        errors = 0;
        checks = 0;
        reset          = 1'b1;
        bus.shift_ctrl = SHIFT_ROR;
        bus.shamt      = 5'd7;
        bus.shift_src  = 32'hDEADBEEF;

        vecs.push_back('{1'b1, SHIFT_SLL, 5'd0,  32'hFFFFFFFF, 32'h00000000, "reset_hold"});
        vecs.push_back('{1'b0, SHIFT_SLL, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, "first_after_reset"});
        vecs.push_back('{1'b0, SHIFT_SLL, 5'd1,  32'd10,       32'd20,       "sll_1"});
        vecs.push_back('{1'b0, SHIFT_SLL, 5'd2,  32'd10,       32'd40,       "sll_2"});
        vecs.push_back('{1'b0, SHIFT_SLL, 5'd3,  32'd10,       32'd80,       "sll_3"});
        vecs.push_back('{1'b0, SHIFT_SRL, 5'd1,  32'hFFFFFFEF, 32'h7FFFFFF7, "srl_1"});
        vecs.push_back('{1'b0, SHIFT_SRL, 5'd10, 32'hFFFFFFEF, 32'h003FFFFF, "srl_10"});
        vecs.push_back('{1'b0, SHIFT_SRL, 5'd31, 32'hFFFFFFEF, 32'h00000001, "srl_31"});
        vecs.push_back('{1'b0, SHIFT_SRA, 5'd1,  32'hFFFFFFEF, 32'hFFFFFFF7, "sra_1"});
        vecs.push_back('{1'b0, SHIFT_SRA, 5'd10, 32'hFFFFFFEF, 32'hFFFFFFFF, "sra_10"});
        vecs.push_back('{1'b0, SHIFT_SRA, 5'd31, 32'hFFFFFFEF, 32'hFFFFFFFF, "sra_31"});
        vecs.push_back('{1'b0, SHIFT_SRA, 5'd4,  32'h7FFFFFF0, 32'h07FFFFFF, "sra_pos"});
        vecs.push_back('{1'b0, SHIFT_ROR, 5'd1,  32'h00000001, 32'h80000000, "ror_1"});
        vecs.push_back('{1'b0, SHIFT_ROR, 5'd8,  32'h12345678, 32'h78123456, "ror_8"});
        vecs.push_back('{1'b0, SHIFT_ROR, 5'd31, 32'h80000001, 32'h00000003, "ror_31"});
        vecs.push_back('{1'b0, SHIFT_SLL, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, "sll_0"});
        vecs.push_back('{1'b0, SHIFT_SRL, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, "srl_0"});
        vecs.push_back('{1'b0, SHIFT_SRA, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, "sra_0"});
        vecs.push_back('{1'b0, SHIFT_ROR, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, "ror_0"});
        vecs.push_back('{1'b0, SHIFT_SLL, 5'd31, 32'h00000003, 32'h80000000, "sll_31"});
        vecs.push_back('{1'b0, SHIFT_SRL, 5'd31, 32'h7FFFFFFF, 32'h00000000, "srl_31_zero"});
        vecs.push_back('{1'b0, SHIFT_SRA, 5'd31, 32'h7FFFFFFF, 32'h00000000, "sra_31_pos"});
        vecs.push_back('{1'b1, SHIFT_SRA, 5'd4,  32'h12345678, 32'h00000000, "reset_midstream"});
        vecs.push_back('{1'b0, SHIFT_ROR, 5'd4,  32'h12345678, 32'h81234567, "after_mid_reset"});

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].op, vecs[i].sh, vecs[i].src);
            check(vecs[i].name, bus.shift_out, vecs[i].exp);
        end

        // Output must hold between edges even while inputs change
        cycle(1'b0, SHIFT_SLL, 5'd4, 32'h0000000F);
        check("latency_one", bus.shift_out, 32'h000000F0);
        held_v = bus.shift_out;
        @(negedge clk);
        bus.shift_ctrl = SHIFT_SRL;
        bus.shamt      = 5'd1;
        bus.shift_src  = 32'hFFFFFFFF;
        #2;
        check("hold_between_edges", bus.shift_out, held_v);
        @(posedge clk);
        #1;
        check("next_edge_update", bus.shift_out, 32'h7FFFFFFF);

        // Back-to-back results, then reset with shift inputs still active
        cycle(1'b0, SHIFT_ROR, 5'd16, 32'hAAAA5555);
        check("b2b_ror16", bus.shift_out, 32'h5555AAAA);
        cycle(1'b1, SHIFT_ROR, 5'd16, 32'hAAAA5555);
        check("reset_priority", bus.shift_out, 32'h00000000);
        cycle(1'b0, SHIFT_SRA, 5'd16, 32'h80000000);
        check("resume_sra16", bus.shift_out, 32'hFFFF8000);

        // Random stream against the arithmetic reference, with occasional resets
        for (int n = 0; n < 1200; n++) begin
            r_op  = shift_op_e'($urandom_range(0, 3));
            r_sh  = 5'($urandom_range(0, 31));
            r_src = $urandom;
            r_rst = ($urandom_range(0, 49) == 0);
            exp_v = r_rst ? 32'h0 : ref_shift(r_op, r_sh, r_src);
            cycle(r_rst, r_op, r_sh, r_src);
            check("random", bus.shift_out, exp_v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift
